// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron vector datapath.
package nn_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width: enough bits to count N elements, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_shadow_reg.sv
// Wide load/clear register holding the vector currently being streamed.
module vec_shadow_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vec_serializer.sv
// Streams a captured packed vector out one element per accepted beat, element 0 first.
// Handshakes: a transfer happens on a rising edge where valid && ready; data is held while valid && !ready.
module vec_serializer
  import nn_pkg::*;
#(
  parameter int  DW     = DW_DEF,
  parameter int  N_ELEM = 4,
  localparam int IDX_W  = idx_width(N_ELEM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*N_ELEM-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy
);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [DW*N_ELEM-1:0] shadow;
  logic                 in_fire;
  logic                 out_fire;

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_idx   = idx;
  assign out_last  = (idx == IDX_W'(N_ELEM - 1));
  assign out_fire  = out_valid && out_ready;

  // out_ready reaches in_ready combinationally so the next vector can load on the last beat.
  assign in_ready = !rst && !clr &&
                    ((state == IDLE) || ((state == SEND) && out_last && out_ready));
  assign in_fire  = in_valid && in_ready;

  vec_shadow_reg #(
    .W (DW * N_ELEM)
  ) u_shadow (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .ld  (in_fire),
    .d   (in_vec),
    .q   (shadow)
  );

  generate
    if (N_ELEM == 1) begin : g_single
      assign out_data = shadow;
    end else begin : g_multi
      logic [DW-1:0] elem [N_ELEM];
      for (genvar k = 0; k < N_ELEM; k++) begin : g_elem
        assign elem[k] = shadow[k*DW +: DW];
      end
      assign out_data = elem[idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (!out_last) begin
              idx <= idx + IDX_W'(1);
            end else if (in_fire) begin
              idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed and randomized checks of vec_serializer against a beat-queue reference model.
module tb_vec_serializer;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = 1 + IW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=4 instance
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*N-1:0] in_vec = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;

  // N=1 instance
  logic          clr1 = 1'b0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [DW-1:0] in_vec1 = '0;
  logic          out_valid1;
  logic          out_ready1 = 1'b1;
  logic [DW-1:0] out_data1;
  logic [0:0]    out_idx1;
  logic          out_last1;
  logic          busy1;

  vec_serializer #(.DW(DW), .N_ELEM(N)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  vec_serializer #(.DW(DW), .N_ELEM(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

  // scoreboard: pending beats packed as {last, idx, data}
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_vec(input logic [DW*N-1:0] v);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({(k == N - 1), IW'(k), v[k*DW +: DW]});
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic          exp_rdy;
    logic          exp_vld;
    logic [EW-1:0] head;
    @(negedge clk);
    exp_vld = (exp_q.size() != 0);
    exp_rdy = !rst && !clr && ((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(exp_vld));
    if (exp_vld) begin
      head = exp_q[0];
      chk("out_data", 32'(out_data), 32'(head[DW-1:0]));
      chk("out_idx", 32'(out_idx), 32'(head[DW +: IW]));
      chk("out_last", 32'(out_last), 32'(head[EW-1]));
    end
    if (rst || clr) begin
      exp_q.delete();
    end else begin
      if (exp_vld && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) push_vec(in_vec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);
    chk("rst1_out_last", 32'(out_last1), 32'd1);
    chk("rst1_out_idx", 32'(out_idx1), 32'd0);

    // basic order
    in_vec = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();

    // backpressure after the first beat
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (5) cycle();

    // back-to-back with in_valid held
    in_vec = 32'h44332211; in_valid = 1'b1;
    cycle();
    in_vec = 32'hDDCCBBAA;
    repeat (4) cycle();
    in_valid = 1'b0;
    repeat (6) cycle();

    // abort at idx 2 with a competing input offer
    in_vec = 32'h87654321; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("abort_pre_idx", 32'(out_idx), 32'd2);
    clr = 1'b1; in_valid = 1'b1; in_vec = 32'hCAFEBABE;
    cycle();
    clr = 1'b0; in_valid = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_idx", 32'(out_idx), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    cycle();
    in_vec = 32'h0F1E2D3C; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // reset mid-vector at idx 1
    in_vec = 32'h99887766; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_idx", 32'(out_idx), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    repeat (2) cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      cycle();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    cycle();

    // single-element instance
    in_vec1 = 8'h5A; in_valid1 = 1'b1;
    chk("n1_in_ready", 32'(in_ready1), 32'd1);
    cycle1();
    in_valid1 = 1'b0;
    chk("n1_out_valid", 32'(out_valid1), 32'd1);
    chk("n1_out_data", 32'(out_data1), 32'h5A);
    chk("n1_out_last", 32'(out_last1), 32'd1);
    chk("n1_out_idx", 32'(out_idx1), 32'd0);
    cycle1();
    chk("n1_idle", 32'(out_valid1), 32'd0);
    in_vec1 = 8'h3C; in_valid1 = 1'b1;
    cycle1();
    in_vec1 = 8'hC3;
    chk("n1_b2b_in_ready", 32'(in_ready1), 32'd1);
    chk("n1_b2b_data0", 32'(out_data1), 32'h3C);
    cycle1();
    in_valid1 = 1'b0;
    chk("n1_b2b_valid1", 32'(out_valid1), 32'd1);
    chk("n1_b2b_data1", 32'(out_data1), 32'hC3);
    chk("n1_b2b_idx1", 32'(out_idx1), 32'd0);
    cycle1();
    chk("n1_b2b_end", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
